// File: rtl/sdram_arbiter.sv
// Round-robin scheduler sharing the sdram controller between a 4-word write port and an RD_BURST-word read port.
// Latency: request->ack 1 cycle, ctl_wr_clk->wr_done 1 cycle, ctl_rd_clk->rd_valid 1 cycle; one transaction in flight.
// Backpressure: level requests wait in IDLE until granted; SDRAM_ARB_TIMEOUT_EN adds a watchdog that aborts stalled waits.
module sdram_arbiter #(
    parameter int RD_BURST = 4,
    parameter int TIMEOUT  = 1023
) (
    input  logic        sclk,
    input  logic        srst_n,
    input  logic        wr_req,
    input  logic [25:0] wr_addr,
    input  logic [63:0] wr_data,
    output logic        wr_ack,
    output logic        wr_done,
    input  logic        rd_req,
    input  logic [25:0] rd_addr,
    output logic        rd_ack,
    output logic        rd_valid,
    output logic [15:0] rd_data,
    output logic        rd_done,
    output logic [25:0] ctl_addr,
    output logic [63:0] ctl_wdata,
    output logic        ctl_wr_trig,
    input  logic        ctl_wr_clk,
    output logic        ctl_rd_en,
    input  logic        ctl_rd_clk,
    input  logic [15:0] ctl_rd_data,
    output logic        err
);

    localparam logic [1:0] S_IDLE    = 2'd0;
    localparam logic [1:0] S_WR_WAIT = 2'd1;
    localparam logic [1:0] S_RD_WAIT = 2'd2;
    localparam logic       GNT_RD    = 1'b0;
    localparam logic       GNT_WR    = 1'b1;
    localparam logic [7:0] LAST_WORD = 8'(RD_BURST - 1);

    if (RD_BURST < 1 || RD_BURST > 255 || TIMEOUT < 1) begin : g_param_check
        $error("sdram_arbiter: RD_BURST must be 1..255 and TIMEOUT at least 1");
    end

    logic [1:0]  state_q, state_d;
    logic        last_grant_q, last_grant_d;
    logic [7:0]  word_cnt_q, word_cnt_d;
    logic [25:0] ctl_addr_q, ctl_addr_d;
    logic [63:0] ctl_wdata_q, ctl_wdata_d;
    logic        ctl_wr_trig_q, ctl_wr_trig_d;
    logic        ctl_rd_en_q, ctl_rd_en_d;
    logic        wr_ack_q, wr_ack_d;
    logic        wr_done_q, wr_done_d;
    logic        rd_ack_q, rd_ack_d;
    logic        rd_valid_q, rd_valid_d;
    logic        rd_done_q, rd_done_d;
    logic [15:0] rd_data_q, rd_data_d;
    logic        grant_wr, grant_rd;

`ifdef SDRAM_ARB_TIMEOUT_EN
    localparam int TW = (TIMEOUT < 2) ? 1 : $clog2(TIMEOUT);
    localparam logic [TW-1:0] TIMER_LAST = TW'(TIMEOUT - 1);
    logic [TW-1:0] timer_q, timer_d;
    logic          err_q, err_d;
    logic          expired;
    // Fires on the edge that would be the TIMEOUT-th silent cycle of a wait.
    assign expired = (timer_q == TIMER_LAST);
`endif

    // On a tie the port that did not win last time is served.
    assign grant_wr = wr_req && (!rd_req || last_grant_q == GNT_RD);
    assign grant_rd = rd_req && !grant_wr;

    always_comb begin
        state_d       = state_q;
        last_grant_d  = last_grant_q;
        word_cnt_d    = word_cnt_q;
        ctl_addr_d    = ctl_addr_q;
        ctl_wdata_d   = ctl_wdata_q;
        ctl_rd_en_d   = ctl_rd_en_q;
        rd_data_d     = rd_data_q;
        ctl_wr_trig_d = 1'b0;
        wr_ack_d      = 1'b0;
        wr_done_d     = 1'b0;
        rd_ack_d      = 1'b0;
        rd_valid_d    = 1'b0;
        rd_done_d     = 1'b0;
`ifdef SDRAM_ARB_TIMEOUT_EN
        timer_d       = timer_q;
        err_d         = 1'b0;
`endif
        case (state_q)
            S_IDLE: begin
`ifdef SDRAM_ARB_TIMEOUT_EN
                timer_d = '0;
`endif
                if (grant_wr) begin
                    ctl_addr_d    = wr_addr;
                    ctl_wdata_d   = wr_data;
                    wr_ack_d      = 1'b1;
                    ctl_wr_trig_d = 1'b1;
                    last_grant_d  = GNT_WR;
                    state_d       = S_WR_WAIT;
                end else if (grant_rd) begin
                    ctl_addr_d   = rd_addr;
                    rd_ack_d     = 1'b1;
                    ctl_rd_en_d  = 1'b1;
                    word_cnt_d   = 8'd0;
                    last_grant_d = GNT_RD;
                    state_d      = S_RD_WAIT;
                end
            end
            S_WR_WAIT: begin
                if (ctl_wr_clk) begin
                    wr_done_d = 1'b1;
                    state_d   = S_IDLE;
                end
`ifdef SDRAM_ARB_TIMEOUT_EN
                else if (expired) begin
                    err_d   = 1'b1;
                    state_d = S_IDLE;
                end else begin
                    timer_d = timer_q + 1'b1;
                end
`endif
            end
            S_RD_WAIT: begin
                if (ctl_rd_clk) begin
                    rd_data_d  = ctl_rd_data;
                    rd_valid_d = 1'b1;
                    word_cnt_d = word_cnt_q + 8'd1;
`ifdef SDRAM_ARB_TIMEOUT_EN
                    timer_d    = '0;
`endif
                    if (word_cnt_q == LAST_WORD) begin
                        rd_done_d   = 1'b1;
                        ctl_rd_en_d = 1'b0;
                        state_d     = S_IDLE;
                    end
                end
`ifdef SDRAM_ARB_TIMEOUT_EN
                else if (expired) begin
                    err_d       = 1'b1;
                    ctl_rd_en_d = 1'b0;
                    state_d     = S_IDLE;
                end else begin
                    timer_d = timer_q + 1'b1;
                end
`endif
            end
            default: begin
                state_d     = S_IDLE;
                ctl_rd_en_d = 1'b0;
            end
        endcase
    end

    always_ff @(posedge sclk or negedge srst_n) begin
        if (!srst_n) begin
            state_q       <= S_IDLE;
            last_grant_q  <= GNT_RD;
            word_cnt_q    <= 8'd0;
            ctl_addr_q    <= '0;
            ctl_wdata_q   <= '0;
            ctl_wr_trig_q <= 1'b0;
            ctl_rd_en_q   <= 1'b0;
            wr_ack_q      <= 1'b0;
            wr_done_q     <= 1'b0;
            rd_ack_q      <= 1'b0;
            rd_valid_q    <= 1'b0;
            rd_done_q     <= 1'b0;
            rd_data_q     <= '0;
        end else begin
            state_q       <= state_d;
            last_grant_q  <= last_grant_d;
            word_cnt_q    <= word_cnt_d;
            ctl_addr_q    <= ctl_addr_d;
            ctl_wdata_q   <= ctl_wdata_d;
            ctl_wr_trig_q <= ctl_wr_trig_d;
            ctl_rd_en_q   <= ctl_rd_en_d;
            wr_ack_q      <= wr_ack_d;
            wr_done_q     <= wr_done_d;
            rd_ack_q      <= rd_ack_d;
            rd_valid_q    <= rd_valid_d;
            rd_done_q     <= rd_done_d;
            rd_data_q     <= rd_data_d;
        end
    end

`ifdef SDRAM_ARB_TIMEOUT_EN
    always_ff @(posedge sclk or negedge srst_n) begin
        if (!srst_n) begin
            timer_q <= '0;
            err_q   <= 1'b0;
        end else begin
            timer_q <= timer_d;
            err_q   <= err_d;
        end
    end
    assign err = err_q;
`else
    assign err = 1'b0;
`endif

    assign wr_ack      = wr_ack_q;
    assign wr_done     = wr_done_q;
    assign rd_ack      = rd_ack_q;
    assign rd_valid    = rd_valid_q;
    assign rd_data     = rd_data_q;
    assign rd_done     = rd_done_q;
    assign ctl_addr    = ctl_addr_q;
    assign ctl_wdata   = ctl_wdata_q;
    assign ctl_wr_trig = ctl_wr_trig_q;
    assign ctl_rd_en   = ctl_rd_en_q;

endmodule

// File: tb/tb_sdram_arbiter.sv
// Bench for sdram_arbiter: directed scenarios plus randomized traffic, scored by a per-edge transaction model.
module tb_sdram_arbiter;

    localparam int RD_BURST = 4;
    localparam int TIMEOUT  = 16;

    logic        sclk = 1'b0;
    logic        srst_n = 1'b0;
    logic        wr_req = 1'b0;
    logic [25:0] wr_addr = '0;
    logic [63:0] wr_data = '0;
    logic        rd_req = 1'b0;
    logic [25:0] rd_addr = '0;
    logic        ctl_wr_clk = 1'b0;
    logic        ctl_rd_clk = 1'b0;
    logic [15:0] ctl_rd_data = '0;
    logic        wr_ack, wr_done, rd_ack, rd_valid, rd_done;
    logic [15:0] rd_data;
    logic [25:0] ctl_addr;
    logic [63:0] ctl_wdata;
    logic        ctl_wr_trig, ctl_rd_en, err;

    always #5 sclk = ~sclk;

    sdram_arbiter #(.RD_BURST(RD_BURST), .TIMEOUT(TIMEOUT)) dut (
        .sclk(sclk), .srst_n(srst_n),
        .wr_req(wr_req), .wr_addr(wr_addr), .wr_data(wr_data), .wr_ack(wr_ack), .wr_done(wr_done),
        .rd_req(rd_req), .rd_addr(rd_addr), .rd_ack(rd_ack), .rd_valid(rd_valid), .rd_data(rd_data),
        .rd_done(rd_done), .ctl_addr(ctl_addr), .ctl_wdata(ctl_wdata), .ctl_wr_trig(ctl_wr_trig),
        .ctl_wr_clk(ctl_wr_clk), .ctl_rd_en(ctl_rd_en), .ctl_rd_clk(ctl_rd_clk),
        .ctl_rd_data(ctl_rd_data), .err(err)
    );

    int n_chk = 0;
    int n_fail = 0;

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_chk++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h, expected %0h (t=%0t)", name, act, exp, $time);
        end
    endtask

    // Transaction-level reference: who owns the controller, how many words are left, what is latched.
    typedef enum logic [1:0] {M_IDLE, M_WR, M_RD} mstate_t;
    mstate_t     m_state = M_IDLE;
    bit          m_last_wr = 1'b0;
    int          m_words = 0;
    int          m_timer = 0;
    bit          m_rd_en = 1'b0;
    logic [25:0] m_addr = '0;
    logic [63:0] m_wdata = '0;
    logic [15:0] rd_exp_q[$];

    logic        s_wr_req, s_rd_req, s_wr_clk, s_rd_clk, pick_wr;
    logic [25:0] s_wr_addr, s_rd_addr;
    logic [63:0] s_wr_data;
    logic [15:0] s_rd_data;
    logic        e_wr_ack, e_wr_done, e_rd_ack, e_rd_valid, e_rd_done, e_trig, e_err;

    always begin
        @(posedge sclk);
        s_wr_req = wr_req;  s_rd_req = rd_req;  s_wr_clk = ctl_wr_clk;  s_rd_clk = ctl_rd_clk;
        s_wr_addr = wr_addr; s_rd_addr = rd_addr; s_wr_data = wr_data;  s_rd_data = ctl_rd_data;
        {e_wr_ack, e_wr_done, e_rd_ack, e_rd_valid, e_rd_done, e_trig, e_err} = '0;
        if (!srst_n) begin
            m_state = M_IDLE; m_last_wr = 1'b0; m_words = 0; m_timer = 0;
            m_rd_en = 1'b0; m_addr = '0; m_wdata = '0;
            rd_exp_q.delete();
        end else begin
            case (m_state)
                M_IDLE: if (s_wr_req || s_rd_req) begin
                    pick_wr = (s_wr_req && s_rd_req) ? !m_last_wr : s_wr_req;
                    m_timer = 0;
                    m_last_wr = pick_wr;
                    if (pick_wr) begin
                        m_addr = s_wr_addr; m_wdata = s_wr_data;
                        e_wr_ack = 1'b1; e_trig = 1'b1; m_state = M_WR;
                    end else begin
                        m_addr = s_rd_addr; m_words = RD_BURST;
                        e_rd_ack = 1'b1; m_rd_en = 1'b1; m_state = M_RD;
                    end
                end
                M_WR: if (s_wr_clk) begin
                    e_wr_done = 1'b1; m_state = M_IDLE;
                end else begin
                    m_timer++;
`ifdef SDRAM_ARB_TIMEOUT_EN
                    if (m_timer == TIMEOUT) begin e_err = 1'b1; m_state = M_IDLE; end
`endif
                end
                M_RD: if (s_rd_clk) begin
                    rd_exp_q.push_back(s_rd_data);
                    e_rd_valid = 1'b1; m_words--; m_timer = 0;
                    if (m_words == 0) begin e_rd_done = 1'b1; m_rd_en = 1'b0; m_state = M_IDLE; end
                end else begin
                    m_timer++;
`ifdef SDRAM_ARB_TIMEOUT_EN
                    if (m_timer == TIMEOUT) begin e_err = 1'b1; m_rd_en = 1'b0; m_state = M_IDLE; end
`endif
                end
                default: m_state = M_IDLE;
            endcase
        end
        #1;
        check("pulses{wack,wdone,rack,rvld,rdone,trig,err}",
              64'({wr_ack, wr_done, rd_ack, rd_valid, rd_done, ctl_wr_trig, err}),
              64'({e_wr_ack, e_wr_done, e_rd_ack, e_rd_valid, e_rd_done, e_trig, e_err}));
        check("ctl_rd_en", 64'(ctl_rd_en), 64'(m_rd_en));
        check("ctl_addr", 64'(ctl_addr), 64'(m_addr));
        check("ctl_wdata", ctl_wdata, m_wdata);
        if (rd_valid) begin
            if (rd_exp_q.size() == 0) check("rd_valid_unexpected", 64'(rd_valid), 64'd0);
            else check("rd_data", 64'(rd_data), 64'(rd_exp_q.pop_front()));
        end
        rd_exp_q.delete();
    end

    task automatic serve_read();
        for (int i = 0; i < RD_BURST; i++) begin
            ctl_rd_clk = 1'b1;
            ctl_rd_data = 16'($urandom);
            @(negedge sclk);
        end
        ctl_rd_clk = 1'b0;
    endtask

    task automatic pulse_reset();
        @(negedge sclk);
        srst_n = 1'b0;
        @(negedge sclk);
        srst_n = 1'b1;
    endtask

    initial begin
        int acks, dones, n, last_done_n, got;
        logic [25:0] a;

        @(negedge sclk);
        check("reset_outputs", 64'({wr_ack, wr_done, rd_ack, rd_valid, rd_done, ctl_wr_trig, ctl_rd_en, err}), 64'd0);
        check("reset_ctl_addr", 64'(ctl_addr), 64'd0);
        srst_n = 1'b1;

        // Single write.
        @(negedge sclk);
        wr_req = 1'b1; wr_addr = 26'h0000104; wr_data = 64'h0003_0002_0001_0000;
        @(negedge sclk);
        check("wr_ack", 64'(wr_ack), 64'd1);
        check("wr_trig", 64'(ctl_wr_trig), 64'd1);
        check("wr_ctl_addr", 64'(ctl_addr), 64'h104);
        check("wr_ctl_wdata", ctl_wdata, 64'h0003_0002_0001_0000);
        wr_req = 1'b0;
        repeat (4) begin
            @(negedge sclk);
            check("wr_trig_single", 64'(ctl_wr_trig), 64'd0);
            check("wr_done_early", 64'(wr_done), 64'd0);
        end
        ctl_wr_clk = 1'b1;
        @(negedge sclk);
        ctl_wr_clk = 1'b0;
        check("wr_done", 64'(wr_done), 64'd1);

        // Single read with words 0..3.
        @(negedge sclk);
        rd_req = 1'b1; rd_addr = 26'h0;
        @(negedge sclk);
        check("rd_ack", 64'(rd_ack), 64'd1);
        check("rd_en_on", 64'(ctl_rd_en), 64'd1);
        rd_req = 1'b0;
        for (int i = 0; i < RD_BURST; i++) begin
            ctl_rd_clk = 1'b1; ctl_rd_data = 16'(i);
            @(negedge sclk);
            check("rd_valid", 64'(rd_valid), 64'd1);
            check("rd_word", 64'(rd_data), 64'(i));
            check("rd_done_last", 64'(rd_done), 64'(i == RD_BURST - 1));
            check("rd_en_hold", 64'(ctl_rd_en), 64'(i != RD_BURST - 1));
        end
        ctl_rd_clk = 1'b0;

        // Both ports held high: W,R,W,R with done->ack gap of one cycle.
        pulse_reset();
        wr_req = 1'b1; rd_req = 1'b1;
        wr_addr = 26'($urandom); wr_data = {$urandom, $urandom}; rd_addr = 26'($urandom);
        acks = 0; dones = 0; n = 0; last_done_n = 0;
        for (int c = 0; c < 200 && dones < 4; c++) begin
            @(negedge sclk);
            n++;
            if (wr_ack || rd_ack) begin
                check("alt_port_is_write", 64'(wr_ack), 64'(acks % 2 == 0));
                if (acks > 0) check("alt_done_to_ack", 64'(n - last_done_n), 64'd1);
                acks++;
                if (acks == 4) begin wr_req = 1'b0; rd_req = 1'b0; end
            end
            if (wr_done || rd_done) begin dones++; last_done_n = n; end
            ctl_wr_clk = ctl_wr_trig; ctl_rd_clk = ctl_rd_en; ctl_rd_data = 16'($urandom);
        end
        ctl_wr_clk = 1'b0; ctl_rd_clk = 1'b0;
        check("alt_transactions", 64'(dones), 64'd4);

        // Read request arriving while a write waits.
        @(negedge sclk);
        wr_req = 1'b1; wr_addr = 26'($urandom);
        @(negedge sclk);
        check("wr_ack_2", 64'(wr_ack), 64'd1);
        wr_req = 1'b0; rd_req = 1'b1; a = 26'($urandom); rd_addr = a;
        repeat (3) begin
            @(negedge sclk);
            check("rd_held_off", 64'(rd_ack), 64'd0);
        end
        ctl_wr_clk = 1'b1;
        @(negedge sclk);
        ctl_wr_clk = 1'b0;
        check("wr_done_2", 64'(wr_done), 64'd1);
        check("rd_not_yet", 64'(rd_ack), 64'd0);
        @(negedge sclk);
        check("rd_ack_after_wr_done", 64'(rd_ack), 64'd1);
        check("rd_addr_latched", 64'(ctl_addr), 64'(a));
        rd_req = 1'b0;
        serve_read();

        // Reset in the middle of a read burst.
        @(negedge sclk);
        rd_req = 1'b1; rd_addr = 26'($urandom);
        @(negedge sclk);
        check("rd_ack_3", 64'(rd_ack), 64'd1);
        rd_req = 1'b0;
        repeat (2) begin
            ctl_rd_clk = 1'b1; ctl_rd_data = 16'($urandom);
            @(negedge sclk);
        end
        ctl_rd_clk = 1'b0;
        check("rd_en_before_rst", 64'(ctl_rd_en), 64'd1);
        #2 srst_n = 1'b0;
        #1;
        check("rd_en_async_drop", 64'(ctl_rd_en), 64'd0);
        check("no_rd_done_on_rst", 64'(rd_done), 64'd0);
        @(negedge sclk);
        srst_n = 1'b1;
        repeat (6) begin
            ctl_rd_clk = 1'b1; ctl_rd_data = 16'($urandom);
            @(negedge sclk);
            check("stray_rd_clk", 64'(rd_valid), 64'd0);
        end
        ctl_rd_clk = 1'b0;

        // Controller never accepts the write data.
        @(negedge sclk);
        wr_req = 1'b1; wr_addr = 26'($urandom);
        @(negedge sclk);
        check("trig_stall", 64'(ctl_wr_trig), 64'd1);
        wr_req = 1'b0; rd_req = 1'b1;
`ifdef SDRAM_ARB_TIMEOUT_EN
        got = -1; n = 0;
        for (int c = 0; c < 60 && got < 0; c++) begin
            @(negedge sclk);
            n++;
            if (err) got = n;
        end
        check("err_delay", 64'(got), 64'(TIMEOUT));
        @(negedge sclk);
        check("err_single", 64'(err), 64'd0);
        check("rd_after_timeout", 64'(rd_ack), 64'd1);
`else
        repeat (40) begin
            @(negedge sclk);
            check("stall_no_err", 64'(err), 64'd0);
            check("stall_no_rd_ack", 64'(rd_ack), 64'd0);
        end
        ctl_wr_clk = 1'b1;
        @(negedge sclk);
        ctl_wr_clk = 1'b0;
        check("stall_wr_done", 64'(wr_done), 64'd1);
        @(negedge sclk);
        check("rd_after_stall", 64'(rd_ack), 64'd1);
`endif
        rd_req = 1'b0;
        serve_read();

        // Random traffic on both ports and on the controller strobes.
        for (int c = 0; c < 4000; c++) begin
            @(negedge sclk);
            if (wr_req) begin
                if (wr_ack && $urandom_range(0, 2) != 0) wr_req = 1'b0;
            end else if ($urandom_range(0, 3) == 0) wr_req = 1'b1;
            if (rd_req) begin
                if (rd_ack && $urandom_range(0, 2) != 0) rd_req = 1'b0;
            end else if ($urandom_range(0, 3) == 0) rd_req = 1'b1;
            wr_addr = 26'($urandom); wr_data = {$urandom, $urandom}; rd_addr = 26'($urandom);
            ctl_wr_clk = ($urandom_range(0, 3) == 0);
            ctl_rd_clk = ($urandom_range(0, 2) == 0);
            ctl_rd_data = 16'($urandom);
        end
        wr_req = 1'b0; rd_req = 1'b0;
        for (int c = 0; c < 200 && m_state != M_IDLE; c++) begin
            @(negedge sclk);
            ctl_wr_clk = 1'b1; ctl_rd_clk = 1'b1; ctl_rd_data = 16'($urandom);
        end
        @(negedge sclk);
        ctl_wr_clk = 1'b0; ctl_rd_clk = 1'b0;
        check("drain_idle", 64'(m_state == M_IDLE), 64'd1);
        repeat (2) @(negedge sclk);

        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end

    initial begin
        #1000000;
        $display("FAIL watchdog: simulation time limit reached, got no summary, expected completion");
        $fatal(1, "watchdog expired");
    end

endmodule

// File: doc/sdram_arbiter.md
Name: sdram_arbiter

Overview:
- Two-port scheduler in front of the `sdram` controller; shares it between a write requester and a read requester.
- Write requester: 4-word bursts. Read requester: RD_BURST-word streams.
- Sequences the controller command interface: address, `writeDataTrig`/`writeDataClk`, `readEnable`/`outdataClk`.
- Round-robin arbitration. One transaction in flight at a time.

Parameters:
- RD_BURST, 4, words read per read grant (1..255)
- TIMEOUT, 1023, watchdog cycles waiting for the controller (used only with the optional feature)

Ports:
- sclk  in  1  system clock
- srst_n  in  1  asynchronous active-low reset
- wr_req  in  1  write request, level
- wr_addr  in  26  {ba[2:0],row[13:0],col[8:0]}
- wr_data  in  64  four 16-bit words; word0 = [15:0]
- wr_ack  out  1  one-cycle pulse: request captured
- wr_done  out  1  one-cycle pulse: controller consumed the data
- rd_req  in  1  read request, level
- rd_addr  in  26  start address, same packing as wr_addr
- rd_ack  out  1  one-cycle pulse: request captured
- rd_valid  out  1  one-cycle pulse per returned word
- rd_data  out  16  returned word, valid with rd_valid
- rd_done  out  1  pulse coincident with the last rd_valid
- ctl_addr  out  26  to controller {ba,row,col}
- ctl_wdata  out  64  to controller writeData
- ctl_wr_trig  out  1  to controller writeDataTrig
- ctl_wr_clk  in  1  from controller writeDataClk: data accepted
- ctl_rd_en  out  1  to controller readEnable
- ctl_rd_clk  in  1  from controller outdataClk: word valid
- ctl_rd_data  in  16  from controller readData
- err  out  1  timeout pulse (tied 0 without the optional feature)

Behaviour:
- Reset (async assert, sync release): every output 0; state IDLE; last_grant = RD, so the first tie goes to the write port.
- States: IDLE, WR_WAIT, RD_WAIT. All outputs are registered.
- IDLE arbitration, evaluated on each edge:
  - only wr_req: write grant
  - only rd_req: read grant
  - both: grant the port opposite last_grant
- Write grant, at the granting edge:
  - latch ctl_addr <= wr_addr and ctl_wdata <= wr_data
  - wr_ack = 1 and ctl_wr_trig = 1 for exactly one cycle
  - last_grant <= WR; go to WR_WAIT
- WR_WAIT:
  - first ctl_wr_clk high: wr_done pulse next cycle, return to IDLE
  - ctl_wr_trig is never re-asserted while waiting
- Read grant, at the granting edge:
  - latch ctl_addr <= rd_addr; rd_ack pulse; ctl_rd_en <= 1
  - word counter = 0; last_grant <= RD; go to RD_WAIT
- RD_WAIT, on each ctl_rd_clk high:
  - rd_data <= ctl_rd_data; rd_valid pulse; counter increments
  - on word RD_BURST-1: rd_done pulses with that rd_valid, ctl_rd_en <= 0 on the same edge, return to IDLE
- Latency:
  - request to ack: 1 cycle
  - ctl_rd_clk to rd_valid: 1 cycle
  - ctl_wr_clk to wr_done: 1 cycle
- Back-to-back: IDLE may grant again on the edge right after returning. A request still high after done counts as a new request.
- Requests are sampled only in IDLE. Requests arriving mid-transaction wait and are never dropped.
- ctl_wr_clk and ctl_rd_clk outside their wait states are ignored and never produce rd_valid or wr_done.
- ctl_rd_clk pulses beyond RD_BURST are ignored.
- ctl_addr and ctl_wdata hold their last value when idle.
- Reset mid-transaction: immediate return to IDLE; ctl_rd_en and ctl_wr_trig drop asynchronously; no done pulse.
- Counter width: 8 bits.

Optional Feature:
- Macro: SDRAM_ARB_TIMEOUT_EN
- Defined:
  - a cycle counter runs in WR_WAIT and RD_WAIT and resets on every ctl_wr_clk/ctl_rd_clk
  - reaching TIMEOUT: err pulses one cycle, ctl_rd_en drops, state returns to IDLE
  - an aborted transaction gets no done pulse; last_grant keeps the aborted port, so the other port gets priority next
- Undefined: no counter; err tied 0; the arbiter waits indefinitely.

Test Plan:
- Write only: wr_req=1, wr_addr=26'h0000104, wr_data=64'h0003_0002_0001_0000.
  - Next cycle: wr_ack=1, ctl_wr_trig=1, ctl_addr=26'h0000104.
  - ctl_wr_clk pulse 5 cycles later gives wr_done 1 cycle after it.
- Read only, RD_BURST=4: rd_req at rd_addr=0.
  - rd_ack, then ctl_rd_en=1.
  - Four ctl_rd_clk pulses with data 0,1,2,3 give rd_valid with rd_data 0,1,2,3.
  - rd_done and ctl_rd_en=0 on the 4th word.
- Simultaneous wr_req and rd_req held high after reset: grants alternate W,R,W,R over 4 transactions, with no idle cycle between the done edge and the next ack.
- rd_req rising during WR_WAIT: no rd_ack until the write completes; rd_ack exactly 1 cycle after wr_done.
- srst_n low during RD_WAIT after 2 words: ctl_rd_en=0 immediately, no rd_done.
  - After release, 6 extra ctl_rd_clk pulses produce no rd_valid.
- SDRAM_ARB_TIMEOUT_EN, TIMEOUT=16: write grant with ctl_wr_clk never asserted.
  - err pulses 16 cycles after ctl_wr_trig; state returns to IDLE; a pending rd_req is granted next.
